// File: rtl/sdram_ctrl_if.sv
// Request/response port of the SDRAM controller.
// The master issues single 32-bit word requests; the slave (controller)
// accepts them with req_ready and answers with a one-cycle rsp_valid pulse.
interface sdram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [24:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sdram_ctrl.sv
// Close-page controller for a 16-bit SDR SDRAM: each 32-bit word request
// becomes ACTIVE, two column commands (low then high halfword), PRECHARGE.
// Power-up init (PRECHARGE ALL, LOAD MODE) runs before any request is taken.
// Optional auto-refresh is enabled by defining SDRAM_CTRL_REFRESH_EN.
module sdram_ctrl #(
    parameter int INIT_CYCLES  = 16,
    parameter int TRCD_CYCLES  = 2,
    parameter int TRP_CYCLES   = 2,
    parameter int TMRD_CYCLES  = 2,
    parameter int REF_INTERVAL = 780,
    parameter int TRFC_CYCLES  = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_ctrl_if.slave bus,
    output logic        cke,
    output logic        cs,
    output logic        ras,
    output logic        cas,
    output logic        we,
    output logic [12:0] a,
    output logic [1:0]  ba,
    output logic [1:0]  dqm,
    inout  wire  [15:0] dq
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    // All-banks precharge sets a[10]; mode word is BL=1, CL=2, sequential.
    localparam logic [12:0] A_PRE_ALL = 13'h0400;
    localparam logic [12:0] A_MODE    = 13'h0020;

    typedef enum logic [3:0] {
        INIT_WAIT, INIT_TRP, INIT_TMRD, IDLE, TRCD_WAIT,
        COL_HI, DRAIN, TRP_WAIT, TRFC_WAIT
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        cke_q;
    logic [3:0]  cmd_q;
    logic [12:0] a_q;
    logic [1:0]  ba_q;
    logic [1:0]  dqm_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [15:0] rdlo_q;
    logic        wen_q;
    logic [22:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        ref_pend_q;
    logic        ref_pend_d;

    logic [12:0] col_lo;
    logic [12:0] col_hi;
    assign col_lo = {4'b0000, addr_q[7:0], 1'b0};
    assign col_hi = {4'b0000, addr_q[7:0], 1'b1};

`ifdef SDRAM_CTRL_REFRESH_EN
    logic [15:0] ref_cnt_q;
    logic        ref_run_q;
    logic        ref_hit;
    logic        ref_clr;
    logic        init_done;

    assign init_done  = (state_q == INIT_TMRD) && (cnt_q == 16'd0);
    assign ref_hit    = ref_run_q && (ref_cnt_q == 16'd0);
    assign ref_clr    = (state_q == IDLE) && ref_pend_q;
    assign ref_pend_d = ref_hit | (ref_pend_q & ~ref_clr);

    // Refresh interval timer: starts when init finishes, flags a pending refresh on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q  <= 16'd0;
            ref_run_q  <= 1'b0;
            ref_pend_q <= 1'b0;
        end else begin
            if (init_done) begin
                ref_run_q <= 1'b1;
                ref_cnt_q <= 16'(REF_INTERVAL - 1);
            end else if (ref_run_q) begin
                ref_cnt_q <= ref_hit ? 16'(REF_INTERVAL - 1) : ref_cnt_q - 16'd1;
            end
            ref_pend_q <= ref_pend_d;
        end
    end
`else
    assign ref_pend_q = 1'b0;
    assign ref_pend_d = 1'b0;
`endif

    // Main sequencer: every output is registered and describes the cycle being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_WAIT;
            cnt_q       <= 16'(INIT_CYCLES);
            cke_q       <= 1'b0;
            cmd_q       <= 4'b1111;
            a_q         <= 13'd0;
            ba_q        <= 2'd0;
            dqm_q       <= 2'd0;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= 16'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rdlo_q      <= 16'd0;
            wen_q       <= 1'b0;
            addr_q      <= 23'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
        end else begin
            cke_q       <= 1'b1;
            cmd_q       <= CMD_NOP;
            a_q         <= 13'd0;
            ba_q        <= 2'd0;
            dqm_q       <= 2'd0;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= 16'd0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                INIT_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        cmd_q   <= CMD_PRE;
                        a_q     <= A_PRE_ALL;
                        cnt_q   <= 16'(TRP_CYCLES);
                        state_q <= INIT_TRP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                INIT_TRP: begin
                    if (cnt_q == 16'd0) begin
                        cmd_q   <= CMD_LMR;
                        a_q     <= A_MODE;
                        cnt_q   <= 16'(TMRD_CYCLES);
                        state_q <= INIT_TMRD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                INIT_TMRD, TRP_WAIT, TRFC_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= IDLE;
                        ready_q <= ~ref_pend_d;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                IDLE: begin
                    if (ref_pend_q) begin
                        cmd_q   <= CMD_REF;
                        ready_q <= 1'b0;
                        cnt_q   <= 16'(TRFC_CYCLES);
                        state_q <= TRFC_WAIT;
                    end else if (bus.req_valid && ready_q) begin
                        wen_q   <= bus.req_wen;
                        addr_q  <= bus.req_addr[24:2];
                        wdata_q <= bus.req_wdata;
                        wstrb_q <= bus.req_wstrb;
                        cmd_q   <= CMD_ACT;
                        ba_q    <= bus.req_addr[24:23];
                        a_q     <= bus.req_addr[22:10];
                        ready_q <= 1'b0;
                        cnt_q   <= 16'(TRCD_CYCLES - 1);
                        state_q <= TRCD_WAIT;
                    end else begin
                        ready_q <= ~ref_pend_d;
                    end
                end
                TRCD_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        cmd_q    <= wen_q ? CMD_WR : CMD_RD;
                        ba_q     <= addr_q[22:21];
                        a_q      <= col_lo;
                        dqm_q    <= wen_q ? wstrb_q[1:0] : 2'b11;
                        dq_oe_q  <= wen_q;
                        dq_out_q <= wen_q ? wdata_q[15:0] : 16'd0;
                        state_q  <= COL_HI;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                COL_HI: begin
                    cmd_q    <= wen_q ? CMD_WR : CMD_RD;
                    ba_q     <= addr_q[22:21];
                    a_q      <= col_hi;
                    dqm_q    <= wen_q ? wstrb_q[3:2] : 2'b11;
                    dq_oe_q  <= wen_q;
                    dq_out_q <= wen_q ? wdata_q[31:16] : 16'd0;
                    cnt_q    <= wen_q ? 16'd1 : 16'd2;
                    state_q  <= DRAIN;
                end
                DRAIN: begin
                    if (cnt_q == 16'd0) begin
                        if (!wen_q) begin
                            rsp_rdata_q <= {dq, rdlo_q};
                        end
                        rsp_valid_q <= 1'b1;
                        cmd_q       <= CMD_PRE;
                        a_q         <= A_PRE_ALL;
                        cnt_q       <= 16'(TRP_CYCLES - 1);
                        state_q     <= TRP_WAIT;
                    end else begin
                        if (!wen_q && cnt_q == 16'd1) begin
                            rdlo_q <= dq;
                        end
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= INIT_WAIT;
                    cnt_q   <= 16'(INIT_CYCLES);
                end
            endcase
        end
    end

    assign cke           = cke_q;
    assign {cs, ras, cas, we} = cmd_q;
    assign a             = a_q;
    assign ba            = ba_q;
    assign dqm           = dqm_q;
    assign dq            = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed testbench for sdram_ctrl with a small CL2 SDRAM device model.
// Built with SDRAM_CTRL_REFRESH_EN undefined (no refresh traffic expected).
module tb_sdram_ctrl;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] LMR = 4'b0000;

    logic        clk;
    logic        rst_n;
    logic        cke, cs, ras, cas, we;
    logic [12:0] a;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    wire  [15:0] dq;

    logic        mdlOe;
    logic [15:0] mdlDq;
    int          assertCount;
    int          failCount;

    sdram_ctrl_if bus ();

    sdram_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .cke   (cke),
        .cs    (cs),
        .ras   (ras),
        .cas   (cas),
        .we    (we),
        .a     (a),
        .ba    (ba),
        .dqm   (dqm),
        .dq    (dq)
    );

    assign dq = mdlOe ? mdlDq : 16'hzzzz;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Device model: keyed by bank/row/column, byte writes gated by active-high dqm, CAS latency 2.
    logic [15:0] mem [int];
    logic [12:0] openRow [4];
    logic        s1v, s2v, s3v;
    int          s1k, s2k, s3k;

    function automatic int mkKey(input logic [1:0] b, input logic [12:0] r, input logic [12:0] c);
        return int'({b, r, c[9:0]});
    endfunction

    initial begin
        s1v = 1'b0; s2v = 1'b0; s3v = 1'b0;
        s1k = 0; s2k = 0; s3k = 0;
        mdlOe = 1'b0; mdlDq = 16'h0000;
        for (int i = 0; i < 4; i++) openRow[i] = 13'd0;
    end

    always @(negedge clk) begin
        logic [15:0] old;
        int k;
        s3v = s2v; s3k = s2k;
        s2v = s1v; s2k = s1k;
        s1v = 1'b0;
        if (cke && {cs, ras, cas, we} == ACT) openRow[ba] = a;
        if (cke && {cs, ras, cas, we} == RD) begin
            s1v = 1'b1;
            s1k = mkKey(ba, openRow[ba], a);
        end
        if (cke && {cs, ras, cas, we} == WR) begin
            k = mkKey(ba, openRow[ba], a);
            old = mem.exists(k) ? mem[k] : 16'h0000;
            if (dqm[0]) old[7:0]  = dq[7:0];
            if (dqm[1]) old[15:8] = dq[15:8];
            mem[k] = old;
        end
        if (s3v) begin
            mdlOe = 1'b1;
            mdlDq = mem.exists(s3k) ? mem[s3k] : 16'h0000;
        end else begin
            mdlOe = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBus(input string tag, input logic [3:0] eCmd, input logic [1:0] eBa,
                            input logic [12:0] eA, input logic [1:0] eDqm);
        checkOutput(tag, {11'd0, cs, ras, cas, we, ba, dqm, a}, {11'd0, eCmd, eBa, eDqm, eA});
    endtask

    task automatic applyStimulus(input logic wen, input logic [24:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        bus.req_valid = 1'b1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput(tag, {cke, cs, ras, cas, we, a, ba, dqm, bus.req_ready, bus.rsp_valid},
                    {1'b0, 4'b1111, 13'd0, 2'd0, 2'd0, 1'b0, 1'b0});
        checkOutput({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
        checkOutput({tag, "_dq"}, {16'd0, dq}, {16'd0, 16'hzzzz});
    endtask

    // Called in the first cycle after reset release; ends in the first IDLE cycle.
    task automatic checkInit(input string tag);
        logic [3:0]  eCmd;
        logic [12:0] eA;
        for (int i = 0; i <= 22; i++) begin
            if (i > 0) tick();
            eCmd = NOP;
            eA   = 13'd0;
            if (i == 16) begin eCmd = PRE; eA = 13'h0400; end
            if (i == 19) begin eCmd = LMR; eA = 13'h0020; end
            checkOutput($sformatf("%s_c%0d", tag, i),
                        {12'd0, cke, bus.rsp_valid, bus.req_ready, cs, ras, cas, we, a},
                        {12'd0, 1'b1, 1'b0, (i == 22), eCmd, eA});
        end
    endtask

    // Starts in an IDLE cycle with a write request presented; ends at the next IDLE cycle.
    task automatic doWrite(input string tag, input bit keepValid, input logic [1:0] eBa,
                           input logic [12:0] eRow, input logic [12:0] eCol,
                           input logic [15:0] dLo, input logic [15:0] dHi,
                           input logic [1:0] mLo, input logic [1:0] mHi);
        checkOutput({tag, "_ready"}, bus.req_ready, 1'b1);
        tick();
        if (!keepValid) bus.req_valid = 1'b0;
        checkBus({tag, "_act"}, ACT, eBa, eRow, 2'b00);
        tick();
        checkBus({tag, "_trcd"}, NOP, 2'd0, 13'd0, 2'b00);
        tick();
        checkBus({tag, "_wr0"}, WR, eBa, eCol, mLo);
        checkOutput({tag, "_dq0"}, {16'd0, dq}, {16'd0, dLo});
        tick();
        checkBus({tag, "_wr1"}, WR, eBa, eCol + 13'd1, mHi);
        checkOutput({tag, "_dq1"}, {16'd0, dq}, {16'd0, dHi});
        tick();
        checkBus({tag, "_gap"}, NOP, 2'd0, 13'd0, 2'b00);
        checkOutput({tag, "_gapz"}, {15'd0, bus.rsp_valid, dq}, {15'd0, 1'b0, 16'hzzzz});
        tick();
        checkBus({tag, "_pre"}, PRE, 2'd0, 13'h0400, 2'b00);
        checkOutput({tag, "_rsp"}, bus.rsp_valid, 1'b1);
        tick();
        checkOutput({tag, "_trp"}, {bus.rsp_valid, bus.req_ready, cs, ras, cas, we}, {2'b00, NOP});
        tick();
        checkOutput({tag, "_idle"}, bus.req_ready, 1'b1);
    endtask

    // Starts in an IDLE cycle with a read request presented; ends at the next IDLE cycle.
    task automatic doRead(input string tag, input bit keepValid, input logic [1:0] eBa,
                          input logic [12:0] eRow, input logic [12:0] eCol,
                          input logic [31:0] eData);
        checkOutput({tag, "_ready"}, bus.req_ready, 1'b1);
        tick();
        if (!keepValid) bus.req_valid = 1'b0;
        checkBus({tag, "_act"}, ACT, eBa, eRow, 2'b00);
        tick();
        checkBus({tag, "_trcd"}, NOP, 2'd0, 13'd0, 2'b00);
        tick();
        checkBus({tag, "_rd0"}, RD, eBa, eCol, 2'b11);
        checkOutput({tag, "_rdz"}, {16'd0, dq}, {16'd0, 16'hzzzz});
        tick();
        checkBus({tag, "_rd1"}, RD, eBa, eCol + 13'd1, 2'b11);
        tick();
        checkOutput({tag, "_cl0"}, {bus.rsp_valid, cs, ras, cas, we}, {1'b0, NOP});
        tick();
        checkOutput({tag, "_cl1"}, {bus.rsp_valid, cs, ras, cas, we}, {1'b0, NOP});
        tick();
        checkBus({tag, "_pre"}, PRE, 2'd0, 13'h0400, 2'b00);
        checkOutput({tag, "_rsp"}, bus.rsp_valid, 1'b1);
        checkOutput({tag, "_data"}, bus.rsp_rdata, eData);
        tick();
        checkOutput({tag, "_trp"}, {bus.rsp_valid, bus.req_ready, cs, ras, cas, we}, {2'b00, NOP});
        checkOutput({tag, "_hold"}, bus.rsp_rdata, eData);
        tick();
        checkOutput({tag, "_idle"}, bus.req_ready, 1'b1);
    endtask

    // Directed sequence: init, writes, byte-masked write, back-to-back, abort by reset.
    initial begin
        assertCount   = 0;
        failCount     = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 25'd0;
        bus.req_wdata = 32'd0;
        bus.req_wstrb = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        checkReset("rst");

        // Request presented during init must wait for the first IDLE cycle.
        applyStimulus(1'b1, 25'h000_0410, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkInit("init");
        checkOutput("init_rdata", bus.rsp_rdata, 32'd0);

        // Bank 0, row 1, column {addr[9:2],0} = 8.
        doWrite("wr1", 1'b0, 2'd0, 13'd1, 13'd8, 16'hBEEF, 16'hDEAD, 2'b11, 2'b11);

        applyStimulus(1'b0, 25'h000_0410, 32'h0, 4'h0);
        doRead("rd1", 1'b0, 2'd0, 13'd1, 13'd8, 32'hDEADBEEF);

        // Only bytes 0 and 2 written: DEADBEEF -> DE22BE44.
        applyStimulus(1'b1, 25'h000_0410, 32'h11223344, 4'b0101);
        doWrite("wr2", 1'b0, 2'd0, 13'd1, 13'd8, 16'h3344, 16'h1122, 2'b01, 2'b01);

        applyStimulus(1'b0, 25'h000_0410, 32'h0, 4'h0);
        doRead("rd2", 1'b0, 2'd0, 13'd1, 13'd8, 32'hDE22BE44);

        // Back-to-back with req_valid held high: bank 3 write then bank 0 read.
        applyStimulus(1'b1, 25'h180_0410, 32'h0BADCAFE, 4'hF);
        doWrite("b2b_wr", 1'b1, 2'd3, 13'd1, 13'd8, 16'hCAFE, 16'h0BAD, 2'b11, 2'b11);
        applyStimulus(1'b0, 25'h000_0410, 32'h0, 4'h0);
        doRead("b2b_rd", 1'b0, 2'd0, 13'd1, 13'd8, 32'hDE22BE44);

        // Empty strobe still issues both WRITEs, but with dqm=00 nothing changes.
        applyStimulus(1'b1, 25'h180_0410, 32'hFFFFFFFF, 4'h0);
        doWrite("wr0s", 1'b0, 2'd3, 13'd1, 13'd8, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00);
        applyStimulus(1'b0, 25'h180_0410, 32'h0, 4'h0);
        doRead("rd0s", 1'b0, 2'd3, 13'd1, 13'd8, 32'h0BADCAFE);

        // Reset asserted during the TRCD wait of a read.
        applyStimulus(1'b0, 25'h000_0410, 32'h0, 4'h0);
        checkOutput("abort_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        checkBus("abort_act", ACT, 2'd0, 13'd1, 2'b00);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("abort_async");
        repeat (2) @(posedge clk);
        #1;
        checkReset("abort_hold");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkInit("reinit");

        applyStimulus(1'b0, 25'h000_0410, 32'h0, 4'h0);
        doRead("rd_after", 1'b0, 2'd0, 13'd1, 13'd8, 32'hDE22BE44);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
